// File: rtl/path_stack.sv
// path_stack: LIFO of maze-cell locations for the solver's traversal path,
// plus a replay engine that streams the stored path bottom-to-top
// (start cell first) over a valid/ready port.
//
// Ports
//   clk, rst           clock, async active-low reset
//   push, pop, clr     stack strobes from the solver controller
//   dIn                location to push
//   top                current top entry (0 when empty)
//   empStck, full      depth == 0 / depth == 2^AW
//   ovf                sticky: push while full or pop while empty
//   rpStart            start replay (honoured only in IDLE)
//   rpValid/rpReady    replay handshake, rpData carries the location
//   rpDone             one-cycle pulse when a replay finishes
//   busy               replay in progress; stack strobes are ignored
module path_stack #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [DW-1:0] dIn,
  output logic [DW-1:0] top,
  output logic          empStck,
  output logic          full,
  output logic          ovf,
  input  logic          rpStart,
  output logic          rpValid,
  input  logic          rpReady,
  output logic [DW-1:0] rpData,
  output logic          rpDone,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} rpState_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   sp, spNxt, spM1;
  logic          ovfNxt;
  logic          wrEn;
  logic [AW-1:0] wrAddr;

  rpState_t      state, stNxt;
  logic [AW-1:0] idx, idxNxt, idxInc;
  logic          rpValidNxt;
  logic [DW-1:0] rpDataNxt;
  logic          lastIdx;

  // sp is AW+1 bits so depth 2^AW is representable; spM1 indexes the top.
  assign spM1    = sp - (AW+1)'(1);
  assign empStck = (sp == '0);
  assign full    = (sp == SP_FULL);
  assign top     = empStck ? '0 : mem[spM1[AW-1:0]];

  assign busy    = (state != IDLE);
  assign rpDone  = (state == FIN);

  // ---------------- stack operation ----------------
  always_comb begin
    spNxt  = sp;
    ovfNxt = ovf;
    wrEn   = 1'b0;
    wrAddr = sp[AW-1:0];
    if (!busy) begin
      if (clr) begin
        spNxt = '0;
      end else if (push && pop && !empStck) begin
        // replace top in place
        wrEn   = 1'b1;
        wrAddr = spM1[AW-1:0];
      end else if (push) begin
        // also covers push+pop on an empty stack
        if (!full) begin
          wrEn  = 1'b1;
          spNxt = sp + (AW+1)'(1);
        end else begin
          ovfNxt = 1'b1;
        end
      end else if (pop) begin
        if (!empStck) spNxt = spM1;
        else          ovfNxt = 1'b1;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= dIn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp  <= '0;
      ovf <= 1'b0;
    end else begin
      sp  <= spNxt;
      ovf <= ovfNxt;
    end
  end

  // ---------------- replay FSM ----------------
  // idx never wraps: at full depth the last index is 2^AW-1 and the
  // handshake on it leaves RUN before idxInc is used.
  assign idxInc  = idx + AW'(1);
  assign lastIdx = ({1'b0, idx} == spM1);

  always_comb begin
    stNxt      = state;
    idxNxt     = idx;
    rpValidNxt = rpValid;
    rpDataNxt  = rpData;
    case (state)
      IDLE: begin
        if (rpStart) begin
          if (!empStck) begin
            stNxt      = RUN;
            idxNxt     = '0;
            rpDataNxt  = mem[0];
            rpValidNxt = 1'b1;
          end else begin
            stNxt = FIN;
          end
        end
      end
      RUN: begin
        if (rpValid && rpReady) begin
          if (lastIdx) begin
            rpValidNxt = 1'b0;
            stNxt      = FIN;
          end else begin
            idxNxt    = idxInc;
            rpDataNxt = mem[idxInc];
          end
        end
      end
      FIN:     stNxt = IDLE;
      default: stNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      rpValid <= 1'b0;
      rpData  <= '0;
    end else begin
      state   <= stNxt;
      idx     <= idxNxt;
      rpValid <= rpValidNxt;
      rpData  <= rpDataNxt;
    end
  end

endmodule
